// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the simple CPU. Holds the instruction
//            field layout, opcode values, ALU operation encoding, the control
//            FSM state enum and the decoded instruction class. The control
//            sequencer, the ALU and data_memory all import this package.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Instruction layout: [19:16] op, [15:14] rd, [13:12] rs, [11:10] rt,
   // [9:8] reserved, [7:0] imm
   localparam int c_iw      = 20;
   localparam int c_op_msb  = 19;
   localparam int c_op_lsb  = 16;
   localparam int c_rd_msb  = 15;
   localparam int c_rd_lsb  = 14;
   localparam int c_rs_msb  = 13;
   localparam int c_rs_lsb  = 12;
   localparam int c_rt_msb  = 11;
   localparam int c_rt_lsb  = 10;
   localparam int c_rsv_msb = 9;
   localparam int c_rsv_lsb = 8;
   localparam int c_imm_msb = 7;
   localparam int c_imm_lsb = 0;

   // Opcodes
   localparam logic [3:0] c_op_nop  = 4'h0;
   localparam logic [3:0] c_op_add  = 4'h1;
   localparam logic [3:0] c_op_sub  = 4'h2;
   localparam logic [3:0] c_op_and  = 4'h3;
   localparam logic [3:0] c_op_or   = 4'h4;
   localparam logic [3:0] c_op_addi = 4'h5;
   localparam logic [3:0] c_op_ld   = 4'h6;
   localparam logic [3:0] c_op_st   = 4'h7;
   localparam logic [3:0] c_op_beq  = 4'h8;
   localparam logic [3:0] c_op_jmp  = 4'h9;
   localparam logic [3:0] c_op_halt = 4'hF;

   // ALU operation encoding
   localparam logic [2:0] c_alu_add = 3'd0;
   localparam logic [2:0] c_alu_sub = 3'd1;
   localparam logic [2:0] c_alu_and = 3'd2;
   localparam logic [2:0] c_alu_or  = 3'd3;

   // Control FSM states
   typedef enum logic [2:0] {
      s_fetch  = 3'd0,
      s_decode = 3'd1,
      s_exec   = 3'd2,
      s_mem    = 3'd3,
      s_wb     = 3'd4,
      s_halt   = 3'd5
   } state_t;

   // Decoded instruction class, used by the sequencer to pick a path
   typedef enum logic [2:0] {
      cls_nop  = 3'd0,
      cls_alu  = 3'd1,
      cls_ld   = 3'd2,
      cls_st   = 3'd3,
      cls_beq  = 3'd4,
      cls_jmp  = 3'd5,
      cls_halt = 3'd6,
      cls_ill  = 3'd7
   } iclass_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_decoder
// Purpose  : Purely combinational opcode decoder. Maps the latched opcode to
//            an instruction class plus the ALU/write-back controls.
// Ports    : op          in  4  opcode field of the instruction register
//            iclass      out 3  instruction class (iclass_t)
//            alu_op      out 3  ALU operation (0 ADD, 1 SUB, 2 AND, 3 OR)
//            alu_src_imm out 1  ALU operand B is the zero-extended imm
//            wb_sel      out 1  write-back source is memory read data
//            illegal     out 1  opcode is undefined
// Revision : 1.0 - initial release
// ============================================================================
module cpu_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] op,
   output iclass_t    iclass,
   output logic [2:0] alu_op,
   output logic       alu_src_imm,
   output logic       wb_sel,
   output logic       illegal
);

   always_comb begin
      iclass      = cls_ill;
      alu_op      = c_alu_add;
      alu_src_imm = 1'b0;
      wb_sel      = 1'b0;
      illegal     = 1'b0;
      case (op)
         c_op_nop:  iclass = cls_nop;
         c_op_add:  begin iclass = cls_alu; alu_op = c_alu_add; end
         c_op_sub:  begin iclass = cls_alu; alu_op = c_alu_sub; end
         c_op_and:  begin iclass = cls_alu; alu_op = c_alu_and; end
         c_op_or:   begin iclass = cls_alu; alu_op = c_alu_or;  end
         c_op_addi: begin
            iclass      = cls_alu;
            alu_op      = c_alu_add;
            alu_src_imm = 1'b1;
         end
         c_op_ld:   begin iclass = cls_ld; wb_sel = 1'b1; end
         c_op_st:   iclass = cls_st;
         // BEQ compares rs and rt by subtracting; alu_zero then means equal
         c_op_beq:  begin iclass = cls_beq; alu_op = c_alu_sub; end
         c_op_jmp:  iclass = cls_jmp;
         c_op_halt: iclass = cls_halt;
         default:   begin iclass = cls_ill; illegal = 1'b1; end
      endcase
   end

endmodule : cpu_decoder
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm
// Purpose  : Multi-cycle control sequencer. Latches each instruction and walks
//            it through FETCH/DECODE/EXEC/MEM/WB, driving PC, register-file,
//            ALU and data-memory controls. Adds HALT, sticky illegal-opcode
//            detection and a wrapping retired-instruction counter.
// Ports    : clk          in  1       system clock, rising edge
//            reset        in  1       asynchronous active-low reset
//            instruction  in  20      instruction from pc_instruction
//            alu_zero     in  1       ALU result is zero (used in EXEC)
//            mem_ready    in  1       data-memory access complete
//            pc_hold      out 1       1 = PC holds this cycle
//            pc_load      out 1       load pc_target instead of incrementing
//            pc_target    out MEM_AW  branch/jump destination
//            rf_raddr_a/b out 2       register read indices (rs, rt)
//            rf_we        out 1       register write strobe
//            rf_waddr     out 2       destination register (rd)
//            alu_op       out 3       ALU operation
//            alu_src_imm  out 1       ALU operand B = imm
//            wb_sel       out 1       0 = ALU result, 1 = memory data
//            mem_re/we    out 1       data-memory strobes
//            mem_addr     out MEM_AW  data-memory address
//            halted       out 1       core is stopped
//            illegal      out 1       sticky undefined-opcode flag
//            instr_count  out CNT_W   retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter int MEM_AW = 8,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [c_iw-1:0]   instruction,
   input  logic              alu_zero,
   input  logic              mem_ready,
   output logic              pc_hold,
   output logic              pc_load,
   output logic [MEM_AW-1:0] pc_target,
   output logic [1:0]        rf_raddr_a,
   output logic [1:0]        rf_raddr_b,
   output logic              rf_we,
   output logic [1:0]        rf_waddr,
   output logic [2:0]        alu_op,
   output logic              alu_src_imm,
   output logic              wb_sel,
   output logic              mem_re,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  instr_count
);

   state_t            r_state;
   state_t            w_next;
   logic [c_iw-1:0]   r_ir;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_count;

   iclass_t           w_cls;
   logic [2:0]        w_dec_alu_op;
   logic              w_dec_src_imm;
   logic              w_dec_wb_sel;
   logic              w_dec_illegal;

   logic              w_retire;
   logic              w_take;
   logic              w_set_ill;
   logic [MEM_AW-1:0] w_imm;
   logic              w_unused_rsvd;

   // Reserved instruction bits carry no meaning
   assign w_unused_rsvd = ^r_ir[c_rsv_msb:c_rsv_lsb];
   assign w_imm         = MEM_AW'(r_ir[c_imm_msb:c_imm_lsb]);

   cpu_decoder u_decoder (
      .op          (r_ir[c_op_msb:c_op_lsb]),
      .iclass      (w_cls),
      .alu_op      (w_dec_alu_op),
      .alu_src_imm (w_dec_src_imm),
      .wb_sel      (w_dec_wb_sel),
      .illegal     (w_dec_illegal)
   );

   // State, instruction register, sticky illegal flag and retire counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= s_fetch;
         r_ir      <= '0;
         r_illegal <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == s_fetch)
            r_ir <= instruction;
         if (w_set_ill)
            r_illegal <= 1'b1;
         if (w_retire)
            r_count <= r_count + CNT_W'(1);
      end
   end

   // Next state plus retire/branch-taken qualifiers
   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_take    = 1'b0;
      w_set_ill = 1'b0;
      case (r_state)
         s_fetch:  w_next = s_decode;
         s_decode: w_next = s_exec;
         s_exec: begin
            if (w_dec_illegal) begin
               w_next    = s_halt;
               w_set_ill = 1'b1;
            end else begin
               case (w_cls)
                  cls_alu:        w_next = s_wb;
                  cls_ld, cls_st: w_next = s_mem;
                  cls_nop: begin
                     w_next   = s_fetch;
                     w_retire = 1'b1;
                  end
                  cls_beq: begin
                     w_next   = s_fetch;
                     w_retire = 1'b1;
                     w_take   = alu_zero;
                  end
                  cls_jmp: begin
                     w_next   = s_fetch;
                     w_retire = 1'b1;
                     w_take   = 1'b1;
                  end
                  default:        w_next = s_halt;
               endcase
            end
         end
         s_mem: begin
            // Access stays posted until the memory signals completion
            if (mem_ready) begin
               if (w_cls == cls_ld) begin
                  w_next = s_wb;
               end else begin
                  w_next   = s_fetch;
                  w_retire = 1'b1;
               end
            end
         end
         s_wb: begin
            w_next   = s_fetch;
            w_retire = 1'b1;
         end
         s_halt:   w_next = s_halt;
         default:  w_next = s_fetch;
      endcase
   end

   // Outputs are decoded from state and IR; the PC advances only on retire
   always_comb begin
      pc_hold     = ~w_retire;
      pc_load     = w_retire & w_take;
      pc_target   = w_imm;
      rf_raddr_a  = r_ir[c_rs_msb:c_rs_lsb];
      rf_raddr_b  = r_ir[c_rt_msb:c_rt_lsb];
      rf_waddr    = r_ir[c_rd_msb:c_rd_lsb];
      rf_we       = (r_state == s_wb);
      wb_sel      = (r_state == s_wb) & w_dec_wb_sel;
      alu_op      = w_dec_alu_op;
      alu_src_imm = w_dec_src_imm;
      mem_re      = (r_state == s_mem) & (w_cls == cls_ld);
      mem_we      = (r_state == s_mem) & (w_cls == cls_st);
      mem_addr    = (r_state == s_mem) ? w_imm : '0;
      halted      = (r_state == s_halt);
      illegal     = r_illegal;
      instr_count = r_count;
   end

endmodule : cpu_control_fsm
`default_nettype wire
